// File: rtl/compass_disp_pkg.sv
// Shared definitions for the compass heading display: converter FSM encoding,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) and the digit decoder.
package compass_disp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } conv_state_e;

  localparam logic [8:0] HeadingMax = 9'd359;
  localparam logic [3:0] ShiftIters = 4'd9;

  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegN     = 7'b0101011;
  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegS     = 7'b0010010;
  localparam logic [6:0] SegW     = 7'b1010101;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = Seg0;
      4'd1:    s = Seg1;
      4'd2:    s = Seg2;
      4'd3:    s = Seg3;
      4'd4:    s = Seg4;
      4'd5:    s = Seg5;
      4'd6:    s = Seg6;
      4'd7:    s = Seg7;
      4'd8:    s = Seg8;
      4'd9:    s = Seg9;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 9-bit binary to 3-digit BCD,
// IDLE -> LOAD -> SHIFT (9 cycles) -> DONE, restartable directly from DONE.
module bin2bcd_seq
  import compass_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q;
  logic [8:0]  bin_q;
  logic [20:0] sh_q;
  logic [3:0]  iter_q;

  // Add-3 on every BCD digit >= 5, then shift the whole register left by one.
  function automatic logic [20:0] dabble(input logic [20:0] s);
    logic [20:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[9+4*k +: 4] >= 4'd5) t[9+4*k +: 4] = t[9+4*k +: 4] + 4'd3;
    end
    return {t[19:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      sh_q    <= '0;
      iter_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q   <= bin;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          sh_q    <= {12'd0, bin_q};
          iter_q  <= '0;
          state_q <= StShift;
        end
        StShift: begin
          sh_q   <= dabble(sh_q);
          iter_q <= iter_q + 4'd1;
          if (iter_q == ShiftIters - 4'd1) state_q <= StDone;
        end
        StDone: begin
          if (start) begin
            bin_q   <= bin;
            state_q <= StLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign bcd  = sh_q[20:9];

endmodule

// File: rtl/heading_display.sv
// Compass heading on a 4-digit multiplexed 7-segment display with a one-deep pending slot.
// HEADING_DISPLAY_DIR_LETTER_EN adds a cardinal letter (n/E/S/W) on the leftmost digit.
module heading_display
  import compass_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] heading,
  input  logic       data_valid,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [8:0]      heading_sat;
  logic            pend_q;
  logic [8:0]      pend_val_q;
  logic            start;
  logic [8:0]      start_bin;
  logic            conv_done;
  logic [11:0]     conv_bcd;
  logic [11:0]     bcd_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [6:0]      digit_seg;
  logic [6:0]      letter_seg;

  assign heading_sat = (heading > HeadingMax) ? HeadingMax : heading;

  // A pulse landing in DONE is newer than anything pending, so it is started directly.
  assign start     = (data_valid && !busy) || (conv_done && (data_valid || pend_q));
  assign start_bin = data_valid ? heading_sat : pend_val_q;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (start_bin),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
    end else begin
      if (conv_done) begin
        pend_q <= 1'b0;
        bcd_q  <= conv_bcd;
      end else if (busy && data_valid) begin
        pend_q     <= 1'b1;
        pend_val_q <= heading_sat;
      end
    end
  end

`ifdef HEADING_DISPLAY_DIR_LETTER_EN
  logic [9:0] disp_val;

  assign disp_val = 10'(bcd_q[11:8]) * 10'd100 + 10'(bcd_q[7:4]) * 10'd10 + 10'(bcd_q[3:0]);

  always_comb begin
    letter_seg = SegN;
    if (disp_val >= 10'd315)      letter_seg = SegN;
    else if (disp_val >= 10'd225) letter_seg = SegW;
    else if (disp_val >= 10'd135) letter_seg = SegS;
    else if (disp_val >= 10'd45)  letter_seg = SegE;
  end
`else
  assign letter_seg = SegBlank;
`endif

  always_comb begin
    digit_seg = SegBlank;
    unique case (idx_q)
      2'd0: digit_seg = seg_digit(bcd_q[3:0]);
      2'd1: if (bcd_q[11:4] != 8'd0) digit_seg = seg_digit(bcd_q[7:4]);
      2'd2: if (bcd_q[11:8] != 4'd0) digit_seg = seg_digit(bcd_q[11:8]);
      2'd3: digit_seg = letter_seg;
      default: digit_seg = SegBlank;
    endcase
  end

  // an and seg come from the same index on the same edge, so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      an    <= 4'b1111;
      seg   <= SegBlank;
    end else begin
      if (cnt_q == CntW'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      an  <= ~(4'b0001 << idx_q);
      seg <= digit_seg;
    end
  end

  assign dp = 1'b1;

endmodule
